sr_latch_ctrl: RTL and testbench
================================

Name: sr_latch_ctrl

Overview:
- Sequences set/clear operations onto a shared bank of NFLAG enable-gated SR latches on behalf of NREQ requesters.
- Round-robin arbitration grants one requester per transaction. The latch enable is pulsed only with s/r stable, so s and r are never both asserted.
- Sits between software or FSM clients and the latch bank; the latch outputs q are read back for completion status.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NFLAG, 8, number of SR latches in the bank (2..16)
- IDXW, 3, width of the flag index; must satisfy 2**IDXW >= NFLAG
- PULSE, 2, enable pulse width in clock cycles (1..15)

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- req  input  NREQ  per-requester request level; held until ack
- op  input  NREQ  per-requester operation: 1 = set, 0 = clear
- idx  input  NREQ*IDXW  packed flag indices; requester i uses bits [i*IDXW +: IDXW]
- ack  output  NREQ  one-cycle one-hot completion pulse to the granted requester
- err  output  1  valid with ack; 1 = readback mismatch or index out of range
- busy  output  1  high in every state except IDLE
- lat_s  output  NFLAG  set lines to the latch bank
- lat_r  output  NFLAG  reset lines to the latch bank
- lat_en  output  NFLAG  enable lines to the latch bank
- lat_q  input  NFLAG  latch outputs, read back

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; rr pointer = 0; ack, err, busy, lat_s, lat_r and lat_en all 0; the operation counter clears.
- FSM states: IDLE, SETUP, PULSE, HOLD, CHECK, DONE.
- IDLE:
  - If any req bit is set, select the first requester at or after the rr pointer (wrapping modulo NREQ).
  - Latch its id, op and idx into internal registers, then go to SETUP.
  - Requests arriving during a transaction wait; they are never dropped.
- Index out of range (idx >= NFLAG):
  - Skip SETUP through CHECK and go straight to DONE with err = 1.
  - No lat_* line toggles.
- SETUP (1 cycle):
  - Drive lat_s[idx] = op and lat_r[idx] = ~op; lat_en stays 0.
  - All other bits stay 0.
- PULSE (PULSE cycles): lat_en[idx] = 1 and s/r are held; a down-counter times the state.
- HOLD (1 cycle): lat_en = 0 while s/r are still held, giving a hold margin.
- CHECK (1 cycle):
  - Deassert lat_s/lat_r.
  - Sample lat_q[idx] and set err = (lat_q[idx] != op).
- DONE (1 cycle):
  - ack[id] = 1 and err is valid; rr pointer = id+1 (wrapping).
  - Return to IDLE. A new grant can occur on the next cycle.
- Invariants:
  - lat_s & lat_r == 0 every cycle.
  - lat_en has at most one bit set.
  - lat_en is never high in the cycle s/r change.
- Latency: a valid request sampled in IDLE gets ack after PULSE+4 cycles (SETUP + PULSE + HOLD + CHECK + DONE); 6 cycles at default.
- Requester drops req mid-transaction: the transaction completes and ack is still pulsed.
- Requester holds req through ack: it re-enters arbitration behind the other requesters.
- Reset mid-transaction: all lat_* drop to 0 immediately; the latch retains its prior or partially-written value; no ack is issued.
- busy = 1 in every state except IDLE.

Optional Feature:
- Macro: SR_LATCH_CTRL_READBACK_EN.
- Defined: the CHECK state exists and err reports readback mismatch OR index out of range.
- Undefined:
  - CHECK is removed; HOLD goes directly to DONE and lat_s/lat_r deassert in DONE.
  - Latency becomes PULSE+3.
  - err reports only index out of range, and lat_q is unused.

Test Plan:
- Reset/idle: rst_n low, then high with req=0 -> all outputs 0, busy=0, no lat_en activity for 20 cycles.
- Single set: req=4'b0001, op[0]=1, idx0=5, lat_q modelled by a behavioural latch -> lat_s[5]=1 from SETUP; lat_en[5]=1 for exactly 2 cycles; ack=4'b0001 with err=0 six cycles after grant; lat_q[5]=1.
- Round-robin fairness: req=4'b1111 held continuously with distinct idx -> ack sequence 0,1,2,3,0; no requester granted twice before the others.
- Conflicting targets: req0 = set flag 3 and req1 = clear flag 3 simultaneously -> serialized transactions (set, then clear); lat_s & lat_r never both 1; final lat_q[3]=0.
- Errors:
  - idx=12 with NFLAG=8 -> ack with err=1 after 1 cycle in DONE; lat_* never asserted.
  - With READBACK_EN and lat_q stuck at 0 for a set -> err=1.
- Async reset mid-PULSE: assert rst_n low while lat_en=1 -> lat_en, lat_s and lat_r go to 0 the same time step (no clock edge); no ack; the next request is serviced normally.

Source files
------------

// File: rtl/sr_latch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sr_latch_ctrl
// Description : Round-robin sequencer that performs set/clear operations on a
//               bank of enable-gated SR latches on behalf of NREQ requesters.
//               Each transaction runs SETUP (s/r driven), PULSE (enable high
//               for PULSE cycles), HOLD (enable low, s/r held) and then an
//               optional CHECK (readback) before a one-cycle DONE with ack.
//               Because lat_en is only high while s/r are stable, s and r are
//               never both asserted.
//
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous active-low reset
//               req     - per-requester request level, held until ack
//               op      - per-requester operation (1 = set, 0 = clear)
//               idx     - packed flag indices, requester i at [i*IDXW +: IDXW]
//               ack     - one-hot, one-cycle completion pulse
//               err     - valid with ack: out-of-range index or readback error
//               busy    - high whenever the FSM is not idle
//               lat_s   - set lines to the latch bank
//               lat_r   - reset lines to the latch bank
//               lat_en  - enable lines to the latch bank
//               lat_q   - latch outputs, read back
//
// Options     : SR_LATCH_CTRL_READBACK_EN - when defined, a CHECK state
//               samples lat_q[idx] and err also flags a readback mismatch.
//               When undefined, HOLD goes straight to DONE and lat_q is unused.
//
// Revision    : 1.0 - initial release
// ============================================================================
module sr_latch_ctrl #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3,
    parameter int PULSE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        op,
    input  logic [NREQ*IDXW-1:0]   idx,
    output logic [NREQ-1:0]        ack,
    output logic                   err,
    output logic                   busy,
    output logic [NFLAG-1:0]       lat_s,
    output logic [NFLAG-1:0]       lat_r,
    output logic [NFLAG-1:0]       lat_en,
    input  logic [NFLAG-1:0]       lat_q
);

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [3:0]       c_pulse_load = 4'(PULSE - 1);
    localparam logic [NFLAG-1:0] c_one_flag   = {{(NFLAG-1){1'b0}}, 1'b1};
    localparam logic [NREQ-1:0]  c_one_req    = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [RRW-1:0]    r_rr;
    logic [RRW-1:0]    r_id;
    logic              r_op;
    logic [IDXW-1:0]   r_idx;
    logic [NREQ-1:0]   r_ack;
    logic              r_err;
    logic              r_busy;
    logic [NFLAG-1:0]  r_lat_s;
    logic [NFLAG-1:0]  r_lat_r;
    logic [NFLAG-1:0]  r_lat_en;

    // Arbitration results
    logic              w_found;
    logic [RRW-1:0]    w_sel_id;
    logic [IDXW-1:0]   w_sel_idx;
    logic              w_sel_op;
    logic              w_sel_oor;
    logic              w_grant;

    // Target of the registered outputs for the next cycle
    logic [RRW-1:0]    w_tgt_id;
    logic [IDXW-1:0]   w_tgt_idx;
    logic              w_tgt_op;
    logic [NFLAG-1:0]  w_hot;
    logic              w_sr_phase;
    logic              w_chk_err;
    logic [NFLAG-1:0]  w_s_nxt;
    logic [NFLAG-1:0]  w_r_nxt;
    logic [NFLAG-1:0]  w_en_nxt;
    logic [NREQ-1:0]   w_ack_nxt;
    logic              w_err_nxt;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester at or after r_rr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        w_found  = 1'b0;
        w_sel_id = r_rr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[(int'(r_rr) + k) % NREQ]) begin
                w_found  = 1'b1;
                w_sel_id = RRW'((int'(r_rr) + k) % NREQ);
            end
        end
    end

    assign w_sel_idx = idx[int'(w_sel_id)*IDXW +: IDXW];
    assign w_sel_op  = op[w_sel_id];
    assign w_sel_oor = (32'(w_sel_idx) >= 32'(NFLAG));

`ifdef SR_LATCH_CTRL_READBACK_EN
    // In CHECK, r_idx still addresses the flag that was written.
    logic [NFLAG-1:0] w_hot_r;
    assign w_hot_r   = c_one_flag << r_idx;
    assign w_chk_err = ((|(lat_q & w_hot_r)) != r_op);
`else
    logic w_unused_lat_q;
    assign w_unused_lat_q = ^lat_q;
    assign w_chk_err      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    // An unreachable flag never touches the bank.
                    w_state_nxt = w_sel_oor ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_PULSE;
                w_cnt_nxt   = c_pulse_load;
            end
            S_PULSE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_HOLD: begin
`ifdef SR_LATCH_CTRL_READBACK_EN
                w_state_nxt = S_CHECK;
`else
                w_state_nxt = S_DONE;
`endif
            end
            S_CHECK: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so every latch-bank line comes
    // straight from a flop and cannot glitch.
    // ------------------------------------------------------------------
    always_comb begin
        w_tgt_id   = w_grant ? w_sel_id  : r_id;
        w_tgt_idx  = w_grant ? w_sel_idx : r_idx;
        w_tgt_op   = w_grant ? w_sel_op  : r_op;
        w_hot      = c_one_flag << w_tgt_idx;
        w_sr_phase = (w_state_nxt == S_SETUP) || (w_state_nxt == S_PULSE) ||
                     (w_state_nxt == S_HOLD);
        w_s_nxt    = (w_sr_phase &&  w_tgt_op) ? w_hot : '0;
        w_r_nxt    = (w_sr_phase && !w_tgt_op) ? w_hot : '0;
        w_en_nxt   = (w_state_nxt == S_PULSE) ? w_hot : '0;
        w_ack_nxt  = (w_state_nxt == S_DONE) ? (c_one_req << w_tgt_id) : '0;
        // A grant that lands directly in DONE is always an out-of-range index.
        w_err_nxt  = (w_state_nxt == S_DONE) ? (w_grant ? 1'b1 : w_chk_err) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_rr     <= '0;
            r_id     <= '0;
            r_op     <= 1'b0;
            r_idx    <= '0;
            r_ack    <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_lat_s  <= '0;
            r_lat_r  <= '0;
            r_lat_en <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            if (w_grant) begin
                r_id  <= w_sel_id;
                r_op  <= w_sel_op;
                r_idx <= w_sel_idx;
            end
            // Pointer moves past the requester just served.
            if (r_state == S_DONE) begin
                r_rr <= (r_id == RRW'(NREQ - 1)) ? '0 : r_id + 1'b1;
            end
            r_ack    <= w_ack_nxt;
            r_err    <= w_err_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_lat_s  <= w_s_nxt;
            r_lat_r  <= w_r_nxt;
            r_lat_en <= w_en_nxt;
        end
    end

    assign ack    = r_ack;
    assign err    = r_err;
    assign busy   = r_busy;
    assign lat_s  = r_lat_s;
    assign lat_r  = r_lat_r;
    assign lat_en = r_lat_en;

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_latch_ctrl
// Description : Directed self-checking bench for sr_latch_ctrl with a
//               behavioural SR latch bank (optionally stuck-at-0 per flag).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_latch_ctrl;

    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IDXW  = 4;
    localparam int PULSE = 2;
`ifdef SR_LATCH_CTRL_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int LAT = RB ? PULSE + 4 : PULSE + 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      op;
    logic [NREQ*IDXW-1:0] idx;
    logic [NREQ-1:0]      ack;
    logic                 err;
    logic                 busy;
    logic [NFLAG-1:0]     lat_s;
    logic [NFLAG-1:0]     lat_r;
    logic [NFLAG-1:0]     lat_en;
    logic [NFLAG-1:0]     lat_q;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cycles = 0;
    int sr_cycles = 0;

    sr_latch_ctrl #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW), .PULSE(PULSE)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .op     (op),
        .idx    (idx),
        .ack    (ack),
        .err    (err),
        .busy   (busy),
        .lat_s  (lat_s),
        .lat_r  (lat_r),
        .lat_en (lat_en),
        .lat_q  (lat_q)
    );

    always #5 clk = ~clk;

    // Behavioural enable-gated SR latch bank
    logic [NFLAG-1:0] q_model = '0;
    logic [NFLAG-1:0] stuck0  = '0;
    always @(lat_en or lat_s or lat_r) begin
        for (int i = 0; i < NFLAG; i++) begin
            if (lat_en[i]) begin
                if (lat_s[i])      q_model[i] = 1'b1;
                else if (lat_r[i]) q_model[i] = 1'b0;
            end
        end
    end
    assign lat_q = q_model & ~stuck0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Continuous invariants on the latch-bank lines
    logic [NFLAG-1:0] prev_s = '0;
    logic [NFLAG-1:0] prev_r = '0;
    always @(negedge clk) begin
        if (|lat_en) en_cycles++;
        if (|(lat_s | lat_r)) sr_cycles++;
        check_val("s_and_r", 32'(lat_s & lat_r), 32'd0);
        check_val("en_onehot", 32'($countones(lat_en) <= 1), 32'd1);
        if ((lat_s != prev_s) || (lat_r != prev_r))
            check_val("en_at_sr_change", 32'(lat_en), 32'd0);
        prev_s = lat_s;
        prev_r = lat_r;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for a nonzero ack sampled 1 time unit after posedge.
    task automatic wait_ack(input string tag, output int cyc);
        bit seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (ack != '0) seen = 1'b1;
        end
        if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // One complete transaction from requester id, with SETUP and timing checks.
    task automatic run_req(input int id, input bit o, input int ix, input bit exp_err,
                           input string tag);
        int  cyc = 0;
        bit  seen = 1'b0;
        int  en0, sr0;
        logic [31:0] hot;
        hot = 32'd1 << ix;
        @(negedge clk);
        en0 = en_cycles;
        sr0 = sr_cycles;
        req[id] = 1'b1;
        op[id]  = o;
        idx[id*IDXW +: IDXW] = IDXW'(ix);
        while (!seen && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1 && ix < NFLAG) begin
                check_val({tag, "_setup_s"},  32'(lat_s),  o ? hot : 32'd0);
                check_val({tag, "_setup_r"},  32'(lat_r),  o ? 32'd0 : hot);
                check_val({tag, "_setup_en"}, 32'(lat_en), 32'd0);
            end
            if (ack != '0) seen = 1'b1;
        end
        check_val({tag, "_latency"}, 32'(cyc), (ix < NFLAG) ? 32'(LAT) : 32'd1);
        check_val({tag, "_ack"}, 32'(ack), 32'd1 << id);
        check_val({tag, "_err"}, 32'(err), 32'(exp_err));
        check_val({tag, "_en_cycles"}, 32'(en_cycles - en0), (ix < NFLAG) ? 32'(PULSE) : 32'd0);
        if (ix >= NFLAG) check_val({tag, "_sr_cycles"}, 32'(sr_cycles - sr0), 32'd0);
        req[id] = 1'b0;
        @(posedge clk); #1;
        check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_ack_once"}, 32'(ack), 32'd0);
    endtask

    initial begin
        int cyc;
        int en0;
        rst_n = 1'b0;
        req   = '0;
        op    = '0;
        idx   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ack",  32'(ack),  32'd0);
        check_val("rst_err",  32'(err),  32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_lat",  32'(lat_s | lat_r | lat_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en0 = en_cycles;
        repeat (20) @(posedge clk);
        #1;
        check_val("idle_en_cycles", 32'(en_cycles - en0), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_ack",  32'(ack),  32'd0);

        // Single set then clear of flag 5
        run_req(0, 1'b1, 5, 1'b0, "set5");
        check_val("set5_q", 32'(lat_q[5]), 32'd1);
        run_req(2, 1'b0, 5, 1'b0, "clr5");
        check_val("clr5_q", 32'(lat_q[5]), 32'd0);

        // Out-of-range index
        run_req(1, 1'b1, 12, 1'b1, "oor");

        // Latch stuck at 0: only a readback build can notice
        stuck0[6] = 1'b1;
        run_req(3, 1'b1, 6, RB, "stuck");
        stuck0 = '0;

        // Round-robin fairness from a freshly reset pointer
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) idx[i*IDXW +: IDXW] = IDXW'(i);
        op  = 4'hF;
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_ack("rr", cyc);
            check_val("rr_order", 32'(ack), 32'd1 << (k % NREQ));
            if (k == 4) req = '0;
        end
        check_val("rr_flags", 32'(lat_q[3:0]), 32'hF);

        // Conflicting set/clear on flag 3, serialized set first
        apply_reset();
        @(negedge clk);
        op[0] = 1'b1; idx[0*IDXW +: IDXW] = IDXW'(3);
        op[1] = 1'b0; idx[1*IDXW +: IDXW] = IDXW'(3);
        req = 4'b0011;
        wait_ack("conf_a", cyc);
        check_val("conf_first_ack", 32'(ack), 32'd1);
        check_val("conf_first_q", 32'(lat_q[3]), 32'd1);
        req[0] = 1'b0;
        wait_ack("conf_b", cyc);
        check_val("conf_second_ack", 32'(ack), 32'd2);
        req = '0;
        check_val("conf_final_q", 32'(lat_q[3]), 32'd0);
        repeat (2) @(posedge clk);

        // Asynchronous reset while the enable pulse is high
        @(negedge clk);
        op[2] = 1'b1; idx[2*IDXW +: IDXW] = IDXW'(7);
        req[2] = 1'b1;
        cyc = 0;
        while (lat_en == '0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("arst_saw_en", 32'(lat_en), 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_en",   32'(lat_en), 32'd0);
        check_val("arst_s",    32'(lat_s),  32'd0);
        check_val("arst_r",    32'(lat_r),  32'd0);
        check_val("arst_busy", 32'(busy),   32'd0);
        req = '0;
        cyc = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack != '0) cyc++;
        end
        check_val("arst_no_ack", 32'(cyc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(2, 1'b0, 7, 1'b0, "post_rst");
        check_val("post_rst_q", 32'(lat_q[7]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
